// File: rtl/i2s_master.sv
// I2S bus master: bclk/lrclk generation, 64-bclk stereo frames, one-entry DAC
// holding register and a registered ADC sample output with overrun detection.
module i2s_master #(
    parameter int unsigned BIT_DEPTH   = 24,
    parameter int unsigned HALF_PERIOD = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    output logic                   bclk,
    output logic                   lrclk,
    output logic                   sdata_o,
    input  logic                   sdata_i,
    input  logic [2*BIT_DEPTH-1:0] dac_sample_data,
    input  logic                   dac_sample_valid,
    output logic                   dac_sample_ready,
    output logic [2*BIT_DEPTH-1:0] adc_sample_data,
    output logic                   adc_sample_valid,
    input  logic                   adc_sample_ready,
    output logic                   dac_underrun,
    output logic                   adc_overrun
);
    localparam int unsigned HC_W = $clog2(HALF_PERIOD);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(HALF_PERIOD - 1);
    localparam int unsigned SW = 2 * BIT_DEPTH;

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state;
    logic [HC_W-1:0]      half_cnt;
    logic [5:0]           pos;
    logic [SW-1:0]        hold_data;
    logic [SW-1:0]        shreg;
    logic [BIT_DEPTH-1:0] cap_l;
    logic [BIT_DEPTH-1:0] cap_r;

    logic       toggle, fall, rise, wrap, frame_start, dac_accept;
    logic       data_cur, data_next;
    logic [5:0] pos_next;

    // Slot positions 1..BIT_DEPTH carry sample bits; the rest are padding.
    function automatic logic in_data(input logic [4:0] slot);
        return (slot != 5'd0) && ({27'd0, slot} <= BIT_DEPTH);
    endfunction

    always_comb begin
        toggle      = (state == RUN) && (half_cnt == HC_LAST);
        fall        = toggle && bclk;
        rise        = toggle && !bclk;
        pos_next    = pos + 6'd1;
        wrap        = fall && (pos == 6'd63);
        frame_start = enable && ((state == IDLE) || wrap);
        dac_accept  = dac_sample_valid && dac_sample_ready;
        data_cur    = in_data(pos[4:0]);
        data_next   = in_data(pos_next[4:0]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            half_cnt         <= '0;
            pos              <= '0;
            bclk             <= 1'b0;
            lrclk            <= 1'b0;
            sdata_o          <= 1'b0;
            hold_data        <= '0;
            shreg            <= '0;
            cap_l            <= '0;
            cap_r            <= '0;
            dac_sample_ready <= 1'b1;
            adc_sample_data  <= '0;
            adc_sample_valid <= 1'b0;
            dac_underrun     <= 1'b0;
            adc_overrun      <= 1'b0;
        end else begin
            dac_underrun <= 1'b0;
            adc_overrun  <= 1'b0;
            if (adc_sample_valid && adc_sample_ready)
                adc_sample_valid <= 1'b0;
            if (dac_accept) begin
                hold_data        <= dac_sample_data;
                dac_sample_ready <= 1'b0;
            end
            case (state)
                IDLE: begin
                    half_cnt <= '0;
                    pos      <= '0;
                    bclk     <= 1'b0;
                    lrclk    <= 1'b0;
                    sdata_o  <= 1'b0;
                    if (enable)
                        state <= RUN;
                end
                RUN: begin
                    if (toggle) begin
                        half_cnt <= '0;
                        bclk     <= !bclk;
                    end else begin
                        half_cnt <= half_cnt + 1'b1;
                    end
                    if (rise && data_cur) begin
                        if (pos[5])
                            cap_r <= {cap_r[BIT_DEPTH-2:0], sdata_i};
                        else
                            cap_l <= {cap_l[BIT_DEPTH-2:0], sdata_i};
                    end
                    if (fall) begin
                        pos   <= pos_next;
                        lrclk <= pos_next[5];
                        if (data_next) begin
                            sdata_o <= shreg[SW-1];
                            shreg   <= shreg << 1;
                        end else begin
                            sdata_o <= 1'b0;
                        end
                    end
                    // The completed frame is always published, even when stopping.
                    if (wrap) begin
                        adc_sample_data  <= {cap_l, cap_r};
                        adc_sample_valid <= 1'b1;
                        if (adc_sample_valid && !adc_sample_ready)
                            adc_overrun <= 1'b1;
                        if (!enable)
                            state <= IDLE;
                    end
                end
            endcase
            // Reads the pre-accept holding state, so a same-cycle accept waits a frame.
            if (frame_start) begin
                if (dac_sample_ready) begin
                    shreg        <= '0;
                    dac_underrun <= 1'b1;
                end else begin
                    shreg <= hold_data;
                end
                dac_sample_ready <= !dac_accept;
            end
        end
    end
endmodule

// File: tb/tb_i2s_master.sv
// Directed bench for i2s_master: frame table with per-frame DAC/ADC expectations,
// plus hand sequences for reset, enable drop and mid-frame reset.
module tb_i2s_master;
    localparam int BD    = 24;
    localparam int HP    = 2;
    localparam int BP    = 2 * HP;
    localparam int FRAME = 64 * BP;

    typedef struct {
        logic [47:0] dac_exp;
        int          offer_t;
        logic [47:0] offer_word;
        logic [23:0] cod_l;
        logic [23:0] cod_r;
        bit          adc_take;
        logic        exp_urun;
        logic [47:0] exp_adc;
        logic        exp_ovr;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, enable, bclk, lrclk, sdata_o, sdata_i;
    logic [47:0] dac_data, adc_data;
    logic        dac_valid, dac_ready, adc_valid, adc_ready, dac_underrun, adc_overrun;

    int          checks = 0;
    int          errors = 0;
    logic [23:0] cod_l, cod_r;
    int          cpos  = 0;
    logic        bclk_q = 1'b0;
    logic        lr_q   = 1'b0;
    vec_t        tbl[6];
    vec_t        drop_vec;

    i2s_master #(.BIT_DEPTH(BD), .HALF_PERIOD(HP)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .bclk(bclk), .lrclk(lrclk), .sdata_o(sdata_o), .sdata_i(sdata_i),
        .dac_sample_data(dac_data), .dac_sample_valid(dac_valid), .dac_sample_ready(dac_ready),
        .adc_sample_data(adc_data), .adc_sample_valid(adc_valid), .adc_sample_ready(adc_ready),
        .dac_underrun(dac_underrun), .adc_overrun(adc_overrun)
    );

    always #5 clk = ~clk;

    // Codec model: follows bclk/lrclk, drives junk 1s on padding positions.
    always @(negedge clk) begin
        logic [23:0] w;
        int m;
        if (lr_q && !lrclk)       cpos = 0;
        else if (!lr_q && lrclk)  cpos = 32;
        else if (bclk_q && !bclk) cpos = cpos + 1;
        bclk_q = bclk;
        lr_q   = lrclk;
        m = cpos % 32;
        w = (cpos < 32) ? cod_l : cod_r;
        if (m >= 1 && m <= BD) sdata_i = w[BD-m];
        else                   sdata_i = (m != 0);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_serial(input logic [47:0] w);
        logic [63:0] s = '0;
        for (int p = 0; p < 64; p++) begin
            int m = p % 32;
            if (m >= 1 && m <= BD) s[p] = (p < 32) ? w[48-m] : w[24-m];
        end
        return s;
    endfunction

    task automatic run_frame(input vec_t v, input int drop_at, input bit skip_end, input string tag);
        int          shape_err = 0;
        int          stray = 0;
        logic [63:0] ser = '0;
        logic        expb, explr;
        cod_l = v.cod_l;
        cod_r = v.cod_r;
        for (int t = 1; t <= FRAME; t++) begin
            dac_valid = (t == v.offer_t);
            if (t == v.offer_t) begin
                check({tag, " dac ready before offer"}, 64'(dac_ready), 64'd1);
                dac_data = v.offer_word;
            end
            adc_ready = v.adc_take && (t == 20);
            if (t == drop_at) enable = 1'b0;
            tick;
            if (v.adc_take && t == 20)
                check({tag, " adc valid cleared"}, 64'(adc_valid), 64'd0);
            if (t == v.offer_t)
                check({tag, " dac ready after accept"}, 64'(dac_ready), 64'd0);
            expb  = (t % BP) >= HP;
            explr = ((t / BP) % 64) >= 32;
            if (bclk !== expb || lrclk !== explr) shape_err++;
            if (t % BP == 0) ser[6'((t / BP) % 64)] = sdata_o;
            if (t < FRAME && (dac_underrun || adc_overrun)) stray++;
        end
        check({tag, " bclk/lrclk shape errors"}, 64'(shape_err), 64'd0);
        check({tag, " stray pulses"}, 64'(stray), 64'd0);
        check({tag, " sdata_o serial"}, ser, exp_serial(v.dac_exp));
        if (!skip_end) begin
            check({tag, " dac_underrun at wrap"}, 64'(dac_underrun), 64'(v.exp_urun));
            check({tag, " adc_overrun at wrap"}, 64'(adc_overrun), 64'(v.exp_ovr));
            check({tag, " adc valid at wrap"}, 64'(adc_valid), 64'd1);
            check({tag, " adc data at wrap"}, 64'(adc_data), 64'(v.exp_adc));
        end
    endtask

    initial begin
        int act;
        tbl[0] = '{48'hA5A5A5_5A5A5A, 0,     48'h0,            24'h123456, 24'hFEDCBA, 1'b0, 1'b1, 48'h123456_FEDCBA, 1'b0};
        tbl[1] = '{48'h0,             41,    48'h800001_7FFFFE, 24'h000001, 24'h800000, 1'b0, 1'b0, 48'h000001_800000, 1'b1};
        tbl[2] = '{48'h800001_7FFFFE, 0,     48'h0,            24'hFFFFFF, 24'h000000, 1'b1, 1'b1, 48'hFFFFFF_000000, 1'b0};
        tbl[3] = '{48'h0,             FRAME, 48'h123456_654321, 24'hAAAAAA, 24'h555555, 1'b0, 1'b1, 48'hAAAAAA_555555, 1'b1};
        tbl[4] = '{48'h0,             0,     48'h0,            24'h5A5A5A, 24'hC3C3C3, 1'b1, 1'b0, 48'h5A5A5A_C3C3C3, 1'b0};
        tbl[5] = '{48'h123456_654321, 0,     48'h0,            24'h000000, 24'hFFFFFF, 1'b1, 1'b1, 48'h000000_FFFFFF, 1'b0};
        drop_vec = '{48'h0, 0, 48'h0, 24'h0F0F0F, 24'hF0F0F0, 1'b0, 1'b0, 48'h0, 1'b0};

        reset = 1'b1; enable = 1'b0; dac_valid = 1'b0; dac_data = '0; adc_ready = 1'b0;
        cod_l = '0; cod_r = '0;
        repeat (3) tick;
        check("reset bclk", 64'(bclk), 64'd0);
        check("reset lrclk", 64'(lrclk), 64'd0);
        check("reset sdata_o", 64'(sdata_o), 64'd0);
        check("reset dac ready", 64'(dac_ready), 64'd1);
        check("reset adc valid", 64'(adc_valid), 64'd0);
        check("reset pulses", 64'({dac_underrun, adc_overrun}), 64'd0);

        reset = 1'b0;
        repeat (5) tick;
        check("idle outputs", 64'({bclk, lrclk, sdata_o, dac_underrun}), 64'd0);

        dac_data = 48'hA5A5A5_5A5A5A;
        dac_valid = 1'b1;
        tick;
        dac_valid = 1'b0;
        check("preload ready falls", 64'(dac_ready), 64'd0);

        enable = 1'b1;
        tick;
        check("entry underrun", 64'(dac_underrun), 64'd0);
        check("entry hold emptied", 64'(dac_ready), 64'd1);

        for (int i = 0; i < 6; i++)
            run_frame(tbl[i], 0, 1'b0, $sformatf("frame%0d", i));

        run_frame(drop_vec, 10 * BP, 1'b1, "drop");
        act = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (bclk || lrclk || sdata_o) act++;
        end
        check("idle after drop activity", 64'(act), 64'd0);

        enable = 1'b1;
        tick;
        check("reentry underrun", 64'(dac_underrun), 64'd1);
        repeat (40 * BP) tick;
        check("pos40 lrclk", 64'(lrclk), 64'd1);
        reset = 1'b1;
        tick;
        check("midframe reset outputs", 64'({bclk, lrclk, sdata_o, dac_underrun, adc_overrun, adc_valid}), 64'd0);
        check("midframe reset dac ready", 64'(dac_ready), 64'd1);
        reset = 1'b0;
        enable = 1'b0;
        act = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (bclk || lrclk || sdata_o) act++;
        end
        check("idle after reset activity", 64'(act), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
